// File: rtl/cpu_pad_pkg.sv
// Shared types for the pin-reduced CPU pad bus multiplexer.
//   pad_cmd_e : beat type shown on pad_cmd (IDLE/ADDR/WDATA/RWAIT)
//   state_e   : transaction FSM states
//   beats()   : number of PAD_W beats needed to move a word of a given width
package cpu_pad_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE  = 2'd0,
    CMD_ADDR  = 2'd1,
    CMD_WDATA = 2'd2,
    CMD_RWAIT = 2'd3
  } pad_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RWAIT,
    S_DONE
  } state_e;

  function automatic int beats(input int width, input int pad_w);
    return width / pad_w;
  endfunction

endpackage

// File: rtl/pad_beat_slicer.sv
// Word register with beat-granular access, used for the data path in both
// directions: it is parallel-loaded with the write word and muxed out one
// beat at a time, or filled beat by beat from the input pads to build the
// read word.
//   clk, reset  : clock, async active-low reset (clears the held word)
//   load        : parallel load of load_word (wins over cap_en)
//   cap_en      : write cap_beat into beat slot sel
//   sel         : beat index, least-significant slice is beat 0
//   beat        : slice sel of the held word
//   word        : the whole held word
module pad_beat_slicer #(
  parameter int WORD_W = 16,
  parameter int PAD_W  = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              cap_en,
  input  logic [PAD_W-1:0]  cap_beat,
  input  logic [SEL_W-1:0]  sel,
  output logic [PAD_W-1:0]  beat,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      word_q <= '0;
    else if (load)   word_q <= load_word;
    else if (cap_en) word_q[int'(sel)*PAD_W +: PAD_W] <= cap_beat;
  end

  assign beat = word_q[int'(sel)*PAD_W +: PAD_W];
  assign word = word_q;

endmodule

// File: rtl/cpu_pad_bus_mux.sv
// Time-multiplexes a CPU memory transaction onto PAD_W output pads and
// gathers read data from PAD_W input pads, least-significant beat first.
//   core_req/we/adr/wdata : transaction request, sampled only when idle
//   core_busy/done/rdata  : status, completion pulse, last read word
//   pad_out/pad_cmd       : outbound beat and its type
//   pad_in/pad_in_valid   : inbound read beat (only used while waiting)
// Optional (macro PAD_PARITY_EN): pad_par_out (odd parity of outbound
// ADDR/WDATA beats), pad_in_par (parity of pad_in), core_perr (sticky read
// parity error, cleared on the next accepted request).
// All outputs are registered: each beat appears the cycle after the FSM
// state that produces it.
module cpu_pad_bus_mux
  import cpu_pad_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int PAD_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_busy,
  output logic              core_done,
  output logic [DATA_W-1:0] core_rdata,
  output logic [PAD_W-1:0]  pad_out,
  output logic [CMD_W-1:0]  pad_cmd,
  input  logic [PAD_W-1:0]  pad_in,
  input  logic              pad_in_valid
`ifdef PAD_PARITY_EN
  ,
  output logic              pad_par_out,
  input  logic              pad_in_par,
  output logic              core_perr
`endif
);

  localparam int ABEATS = beats(ADDR_W, PAD_W);
  localparam int DBEATS = beats(DATA_W, PAD_W);
  localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int CNT_W  = $clog2(MAXB + 1);
  localparam logic [CNT_W-1:0] ALAST = CNT_W'(ABEATS - 1);
  localparam logic [CNT_W-1:0] DLAST = CNT_W'(DBEATS - 1);

  if ((ADDR_W % PAD_W) != 0 || (DATA_W % PAD_W) != 0) begin : g_bad_width
    $error("cpu_pad_bus_mux: ADDR_W and DATA_W must be multiples of PAD_W");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [PAD_W-1:0]    pad_out_q, pad_out_d;
  pad_cmd_e            cmd_q, cmd_d;

  logic                load, cap_en;
  logic [DATA_W-1:0]   load_word, shadow;
  logic [PAD_W-1:0]    tx_beat;

  // Data word: holds wdata on writes; on reads it is zeroed at accept and
  // becomes the shadow word filled beat by beat.
  pad_beat_slicer #(.WORD_W(DATA_W), .PAD_W(PAD_W), .SEL_W(CNT_W)) u_data (
    .clk(clk), .reset(reset), .load(load), .load_word(load_word),
    .cap_en(cap_en), .cap_beat(pad_in), .sel(cnt_q),
    .beat(tx_beat), .word(shadow)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    adr_d     = adr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    pad_out_d = '0;
    cmd_d     = CMD_IDLE;
    load      = 1'b0;
    load_word = '0;
    cap_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (core_req) begin
          adr_d     = core_adr;
          we_d      = core_we;
          load      = 1'b1;
          load_word = core_we ? core_wdata : '0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        cmd_d     = CMD_ADDR;
        pad_out_d = adr_q[int'(cnt_q)*PAD_W +: PAD_W];
        if (cnt_q == ALAST) begin
          cnt_d   = '0;
          state_d = we_q ? S_WDATA : S_RWAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WDATA: begin
        cmd_d     = CMD_WDATA;
        pad_out_d = tx_beat;
        if (cnt_q == DLAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RWAIT: begin
        cmd_d = CMD_RWAIT;
        if (pad_in_valid) begin
          cap_en = 1'b1;
          if (cnt_q == DLAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        // Shadow already holds the last beat, captured on the previous edge.
        if (!we_q) rdata_d = shadow;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      pad_out_q <= '0;
      cmd_q     <= CMD_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      pad_out_q <= pad_out_d;
      cmd_q     <= cmd_d;
    end
  end

  assign core_busy  = busy_q;
  assign core_done  = done_q;
  assign core_rdata = rdata_q;
  assign pad_out    = pad_out_q;
  assign pad_cmd    = cmd_q;

`ifdef PAD_PARITY_EN
  logic par_q, perr_q, beat_bad;

  // Odd parity: pad bits plus parity bit must hold an odd number of ones.
  assign beat_bad = ~(^{pad_in, pad_in_par});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q <= (cmd_d == CMD_ADDR || cmd_d == CMD_WDATA) ? ~^pad_out_d : 1'b0;
      if (load)                    perr_q <= 1'b0;
      else if (cap_en && beat_bad) perr_q <= 1'b1;
    end
  end

  assign pad_par_out = par_q;
  assign core_perr   = perr_q;
`endif

endmodule

// File: tb/tb_cpu_pad_bus_mux.sv
module tb_cpu_pad_bus_mux;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        core_req = 1'b0, core_we = 1'b0;
  logic [15:0] core_adr = '0, core_wdata = '0;
  logic        core_busy, core_done;
  logic [15:0] core_rdata;
  logic [7:0]  pad_out;
  logic [1:0]  pad_cmd;
  logic [7:0]  pad_in = '0;
  logic        pad_in_valid = 1'b0;

  logic        req32 = 1'b0, we32 = 1'b0;
  logic [31:0] adr32 = '0, wd32 = '0;
  logic        busy32, done32;
  logic [31:0] rdata32;
  logic [7:0]  pout32;
  logic [1:0]  cmd32;
  logic [7:0]  pin32 = '0;
  logic        pval32 = 1'b0;

`ifdef PAD_PARITY_EN
  logic pad_par_out, core_perr;
  logic pad_in_par = 1'b0;
  logic par32, perr32;
  logic pin_par32 = 1'b0;
`endif

  cpu_pad_bus_mux dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr),
    .core_wdata(core_wdata), .core_busy(core_busy), .core_done(core_done),
    .core_rdata(core_rdata), .pad_out(pad_out), .pad_cmd(pad_cmd),
    .pad_in(pad_in), .pad_in_valid(pad_in_valid)
`ifdef PAD_PARITY_EN
    , .pad_par_out(pad_par_out), .pad_in_par(pad_in_par), .core_perr(core_perr)
`endif
  );

  cpu_pad_bus_mux #(.ADDR_W(32), .DATA_W(32), .PAD_W(8)) dut32 (
    .clk(clk), .reset(reset),
    .core_req(req32), .core_we(we32), .core_adr(adr32),
    .core_wdata(wd32), .core_busy(busy32), .core_done(done32),
    .core_rdata(rdata32), .pad_out(pout32), .pad_cmd(cmd32),
    .pad_in(pin32), .pad_in_valid(pval32)
`ifdef PAD_PARITY_EN
    , .pad_par_out(par32), .pad_in_par(pin_par32), .core_perr(perr32)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  beat_t       beat_q[$];
  beat_t       beat32_q[$];
  logic [15:0] done_q[$];
  int          done32_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] c, input logic [7:0] d);
    beat_t b;
    b.cmd  = c;
    b.data = d;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a 16-bit transaction from an idle slot; returns just after the
  // accepting edge with core_req dropped.
  task automatic start(input logic we, input logic [15:0] adr, input logic [15:0] wd);
    core_req = 1'b1; core_we = we; core_adr = adr; core_wdata = wd;
    beat_q.push_back(mk(2'd1, adr[7:0]));
    beat_q.push_back(mk(2'd1, adr[15:8]));
    if (we) begin
      beat_q.push_back(mk(2'd2, wd[7:0]));
      beat_q.push_back(mk(2'd2, wd[15:8]));
    end
    tick();
    core_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (core_busy) bsy++;
      if (core_done) break;
    end
    chk("done_within_budget", core_done, 1);
  endtask

  // Scoreboard monitors: pop an expectation whenever the DUT shows a beat or
  // a completion pulse.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      if (pad_cmd == 2'd1 || pad_cmd == 2'd2) begin
        if (beat_q.size() == 0) chk("unexpected_beat", {pad_cmd, pad_out}, 0);
        else begin
          e = beat_q.pop_front();
          chk("beat", {pad_cmd, pad_out}, e);
        end
      end
      if (core_done) begin
        if (done_q.size() == 0) chk("unexpected_done", core_done, 0);
        else chk("done_rdata", core_rdata, done_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      if (cmd32 == 2'd1 || cmd32 == 2'd2) begin
        if (beat32_q.size() == 0) chk("unexpected_beat32", {cmd32, pout32}, 0);
        else begin
          e = beat32_q.pop_front();
          chk("beat32", {cmd32, pout32}, e);
        end
      end
      if (done32) done32_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bsy;
    logic [31:0] a32, w32;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", core_busy, 0);
    chk("rst_done", core_done, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_pad_out", pad_out, 0);
    chk("rst_pad_cmd", pad_cmd, 0);
    reset = 1'b1;
    tick();

    // Write 0x1234 <- 0xBEEF
    start(1'b1, 16'h1234, 16'hBEEF);
    done_q.push_back(16'h0000);
    wait_done(20, cyc, bsy);
    chk("wr_done_latency", cyc, 6);
    chk("wr_busy_cycles", bsy, 5);

    // Read 0x00A0 with stalls; valid during ADDR beats must be ignored
    tick();
    pad_in = 8'h99; pad_in_valid = 1'b1;
    start(1'b0, 16'h00A0, 16'h0000);
    tick();
    tick();
    pad_in = 8'hAD;
    tick();
    pad_in_valid = 1'b0; pad_in = 8'h77;
    chk("rwait_cmd0", pad_cmd, 3);
    tick();
    chk("rwait_cmd1", pad_cmd, 3);
    chk("rwait_pad_out", pad_out, 0);
    tick();
    chk("rwait_cmd2", pad_cmd, 3);
    pad_in = 8'hDE; pad_in_valid = 1'b1;
    done_q.push_back(16'hDEAD);
    tick();
    pad_in_valid = 1'b0;
    wait_done(10, cyc, bsy);
    chk("rd_done_after_last_beat", cyc, 2);

    // Busy rejection: 0xFFFF request held through the rest of the write,
    // including its done cycle, then a back-to-back accept one cycle later
    tick();
    start(1'b1, 16'h1234, 16'h5678);
    done_q.push_back(16'hDEAD);
    tick();
    tick();
    core_req = 1'b1; core_we = 1'b1; core_adr = 16'hFFFF; core_wdata = 16'hFFFF;
    tick();
    tick();
    tick();
    chk("reject_done_pulse", core_done, 1);
    start(1'b1, 16'h0042, 16'h0007);
    done_q.push_back(16'hDEAD);
    wait_done(20, cyc, bsy);
    chk("b2b_done_latency", cyc, 6);
    repeat (4) tick();

    // Reset mid-read after the first beat
    start(1'b0, 16'h0010, 16'h0000);
    tick();
    tick();
    pad_in = 8'h55; pad_in_valid = 1'b1;
    tick();
    pad_in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_busy", core_busy, 0);
    chk("mid_rst_done", core_done, 0);
    chk("mid_rst_rdata", core_rdata, 0);
    chk("mid_rst_pad_out", pad_out, 0);
    chk("mid_rst_pad_cmd", pad_cmd, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) tick();
    start(1'b0, 16'h0020, 16'h0000);
    tick();
    tick();
    pad_in = 8'h11; pad_in_valid = 1'b1;
    tick();
    tick();
    pad_in_valid = 1'b0;
    done_q.push_back(16'h1111);
    wait_done(10, cyc, bsy);
    chk("rd_after_rst_latency", cyc, 2);

    // 32-bit instance: 4 address beats then 4 data beats
    tick();
    a32 = 32'h89AB_CDEF;
    w32 = 32'h0123_4567;
    for (int i = 0; i < 4; i++) beat32_q.push_back(mk(2'd1, a32[i*8 +: 8]));
    for (int i = 0; i < 4; i++) beat32_q.push_back(mk(2'd2, w32[i*8 +: 8]));
    req32 = 1'b1; we32 = 1'b1; adr32 = a32; wd32 = w32;
    tick();
    req32 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (done32) break;
    end
    chk("w32_done_latency", cyc, 10);

`ifdef PAD_PARITY_EN
    // Bad parity on first read beat: read completes, error is sticky
    tick();
    start(1'b0, 16'h0003, 16'h0000);
    tick();
    chk("par_out_addr", pad_par_out, 1);
    tick();
    pad_in = 8'h01; pad_in_par = 1'b1; pad_in_valid = 1'b1;
    tick();
    pad_in = 8'h00; pad_in_par = 1'b1;
    tick();
    pad_in_valid = 1'b0;
    done_q.push_back(16'h0001);
    wait_done(10, cyc, bsy);
    chk("perr_set", core_perr, 1);
    tick();
    tick();
    chk("perr_sticky", core_perr, 1);
    start(1'b1, 16'h0000, 16'h0000);
    done_q.push_back(16'h0001);
    chk("perr_cleared", core_perr, 0);
    wait_done(20, cyc, bsy);
`endif

    repeat (4) tick();
    chk("beat_q_drained", beat_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("beat32_q_drained", beat32_q.size(), 0);
    chk("done32_count", done32_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cpu_pad_bus_mux.md
Name: cpu_pad_bus_mux

Overview:
Parametrised, pin-reduced successor to the flat one-pad-per-bit CPU memory interface. It sits between the CPU core and the pad ring. It time-multiplexes the core's address and write data onto PAD_W output pads, and gathers read data from PAD_W input pads in beats. This cuts pad count from 2*DATA_W+ADDR_W to about 2*PAD_W+4 for larger-width CPU generations.

Parameters:
- ADDR_W, 16, core address width; must be a multiple of PAD_W.
- DATA_W, 16, core data width; must be a multiple of PAD_W.
- PAD_W, 8, pads per direction (beat width).

Ports:
- clk  in  1  single clock (the core clock, taken after its input pad).
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  start-transaction pulse; sampled only when core_busy=0.
- core_we  in  1  1=write, 0=read; sampled with core_req.
- core_adr  in  ADDR_W  transaction address; sampled with core_req.
- core_wdata  in  DATA_W  write data; sampled with core_req.
- core_busy  out  1  transaction in progress.
- core_done  out  1  one-cycle pulse when a transaction completes.
- core_rdata  out  DATA_W  last completed read word; held until the next read completes.
- pad_out  out  PAD_W  outbound beat to the output pads.
- pad_cmd  out  2  beat type: 0=IDLE, 1=ADDR, 2=WDATA, 3=RWAIT.
- pad_in  in  PAD_W  inbound read beat from the input pads.
- pad_in_valid  in  1  pad_in holds a valid read beat this cycle.

Behaviour:
- Derived constants: ABEATS=ADDR_W/PAD_W, DBEATS=DATA_W/PAD_W. Beat order is least-significant slice first.
- All outputs are registered.
- Reset values: core_busy=0, core_done=0, core_rdata=0, pad_out=0, pad_cmd=IDLE. The FSM resets to S_IDLE and the beat counter to 0.
- S_IDLE:
  - core_busy=0.
  - If core_req=1, latch adr/we/wdata, set core_busy, go to S_ADDR with beat counter = 0.
- S_ADDR:
  - Each cycle drives pad_cmd=ADDR and pad_out=adr slice[cnt].
  - After ABEATS cycles: if we=1 go to S_WDATA, else go to S_RWAIT. Counter resets to 0.
- S_WDATA:
  - Each cycle drives pad_cmd=WDATA and pad_out=wdata slice[cnt].
  - After DBEATS cycles, go to S_DONE.
- S_RWAIT:
  - Drives pad_cmd=RWAIT and pad_out=0.
  - Each cycle with pad_in_valid=1 captures pad_in into shadow slice[cnt] and increments cnt.
  - Cycles without valid stall indefinitely.
  - When the DBEATS-th beat is captured, go to S_DONE.
- S_DONE:
  - Pulses core_done for one cycle and clears core_busy.
  - For a read, copies the shadow word into core_rdata in the same cycle; for a write, core_rdata is unchanged.
  - pad_cmd=IDLE; returns to S_IDLE.
- Latency:
  - Write: core_req accepted at edge 0. The first ADDR beat is visible after edge 1. core_done is visible after edge 1+ABEATS+DBEATS.
  - Read: core_done is visible one cycle after the edge that captures the last read beat.
- Boundary conditions:
  - core_req while busy is ignored (no queuing).
  - core_req in the S_DONE cycle is ignored; the earliest re-accept is the following S_IDLE cycle.
  - pad_in_valid outside S_RWAIT is ignored.
  - Back-to-back requests: the minimum inter-transaction gap is 1 idle cycle.
- Reset asserted mid-transaction:
  - Immediate return to reset values.
  - The partial shadow word is discarded; core_rdata is cleared to 0.
  - No core_done is issued.
- Elaboration fails if ADDR_W%PAD_W!=0 or DATA_W%PAD_W!=0.

Optional Feature:
- Macro: PAD_PARITY_EN.
- When defined, two extra ports exist:
  - pad_par_out (out, 1): odd parity of pad_out on every ADDR/WDATA beat; 0 when IDLE.
  - pad_in_par (in, 1): parity bit accompanying pad_in.
- Each captured read beat is checked against pad_in_par.
- Any mismatch sets core_perr (out, 1). core_perr is a sticky error, cleared on the next accepted core_req or on reset.
- The read still completes normally.
- When undefined, none of these ports or checks exist and the behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pad_pkg holds:
  - the pad_cmd enum (CMD_IDLE/ADDR/WDATA/RWAIT);
  - the state enum (S_IDLE/S_ADDR/S_WDATA/S_RWAIT/S_DONE);
  - a beats(width, pad_w) function;
  - the 2-bit command width constant.
- One natural sub-module, pad_beat_slicer: a parametrised word-to-beat mux plus beat-to-word capture register indexed by the beat counter. It is instantiated for both directions.

Test Plan:
- Write, defaults: core_req with we=1, adr=0x1234, wdata=0xBEEF.
  - Response: pad_out/pad_cmd sequence 0x34/1, 0x12/1, 0xEF/2, 0xBE/2, then core_done one cycle later.
  - core_busy high for exactly 5 cycles.
- Read with stalls: we=0, adr=0x00A0; pad_in beats 0xAD, (2 invalid cycles), 0xDE.
  - Response: core_rdata=0xDEAD with core_done one cycle after the 0xDE capture.
  - pad_cmd=3 throughout the wait.
- Busy rejection: a second core_req (adr=0xFFFF) mid-write.
  - Response: ignored; pad_out never shows 0xFF ADDR beats; exactly one core_done.
- Reset mid-read: reset low after the first read beat 0x55.
  - Response: all outputs 0 immediately (async); no core_done.
  - A following read of 0x1111 returns 0x1111, not a merged value.
- Parameter sweep: ADDR_W=32, DATA_W=32, PAD_W=8, write adr=0x89ABCDEF.
  - Response: 4 ADDR beats EF, CD, AB, 89, then 4 WDATA beats.
- PAD_PARITY_EN: read beat 0x01 with pad_in_par=1 (bad).
  - Response: core_perr=1 after completion; cleared on the next accepted core_req.
